// File: rtl/switch_debouncer.sv
// Purpose : synchronise and debounce slide-switch inputs; clean level plus 1-cycle rise/fall/changed pulses.
// Latency : SYNC_STAGES + DEBOUNCE_CYCLES edges from a clean raw step to sw (6 edges at SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Backpressure: none; free-running level filter, pulses are single-cycle and never held.
//
// Ports:
//   clk        in   1      system clock (same domain as processorWrapper)
//   rst        in   1      asynchronous active-high reset
//   swRaw      in   WIDTH  raw pad levels, asynchronous to clk
//   sw         out  WIDTH  debounced level (registered)
//   swRise     out  WIDTH  1-cycle pulse per bit on sw 0->1 (registered)
//   swFall     out  WIDTH  1-cycle pulse per bit on sw 1->0 (registered)
//   swChanged  out  1      1-cycle pulse when any bit of sw changes (registered)
module switch_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] swRaw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] swRise,
    output logic [WIDTH-1:0] swFall,
    output logic             swChanged
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
    // DEBOUNCE_CYCLES==1 still elaborates (count then always sits at 0).
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,  // synchronised level agrees with sw
        PENDING = 1'b1   // disagreement being timed
    } bitPhase_t;

    logic [WIDTH-1:0] syncReg [SYNC_STAGES];
    logic [WIDTH-1:0] syncN;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cntNext [WIDTH];
    bitPhase_t        phase   [WIDTH];
    logic [WIDTH-1:0] accept;

    assign syncN = syncReg[SYNC_STAGES-1];

    // Synchroniser chain; stage 0 is the only flop that sees the async pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncReg[s] <= '0;
            end
        end else begin
            syncReg[0] <= swRaw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncReg[s] <= syncReg[s-1];
            end
        end
    end

    // Per-bit filter decision. A match at any point drops the bit back to
    // STABLE with a cleared count; the count never holds or counts down.
    // On the final mismatch cycle the new level is taken and the count is
    // cleared in the same edge, so the counter can never wrap.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cntNext[i] = '0;
            phase[i]   = (syncN[i] != sw[i]) ? PENDING : STABLE;
            case (phase[i])
                PENDING: begin
                    if (cnt[i] == CNT_LAST) begin
                        accept[i] = 1'b1;
                    end else begin
                        cntNext[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    cntNext[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw        <= '0;
            swRise    <= '0;
            swFall    <= '0;
            swChanged <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cntNext[i];
            end
            // An accepted bit always flips, so XOR is the new level and the
            // synced value tells the direction of the edge.
            sw        <= sw ^ accept;
            swRise    <= accept & syncN;
            swFall    <= accept & ~syncN;
            swChanged <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Purpose : self-checking bench for switch_debouncer (WIDTH=16, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a directed sequence followed by random switch activity.
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int DC = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  swRaw;
    logic [W-1:0]  sw;
    logic [W-1:0]  swRise;
    logic [W-1:0]  swFall;
    logic          swChanged;

    int total = 0;
    int bad   = 0;

    // Reference model: a raw-sample delay line for the synchroniser and a
    // sliding window of the last DC synced samples. A bit is accepted when
    // every sample in the window disagrees with the current clean level.
    logic [W-1:0] mPipe1, mPipe2;
    logic [W-1:0] win[$];
    logic [W-1:0] mSw, mRise, mFall;
    logic         mChg;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .swRaw    (swRaw),
        .sw       (sw),
        .swRise   (swRise),
        .swFall   (swFall),
        .swChanged(swChanged)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPipe1 = '0;
        mPipe2 = '0;
        win.delete();
        mSw   = '0;
        mRise = '0;
        mFall = '0;
        mChg  = 1'b0;
    endtask

    task automatic modelEdge(input logic [W-1:0] rawNow);
        logic [W-1:0] seen;
        logic [W-1:0] acc;
        bit           allDiff;
        seen   = mPipe2;
        mPipe2 = mPipe1;
        mPipe1 = rawNow;
        win.push_back(seen);
        if (win.size() > DC) void'(win.pop_front());
        acc = '0;
        if (win.size() == DC) begin
            for (int i = 0; i < W; i++) begin
                allDiff = 1'b1;
                foreach (win[j]) begin
                    if (win[j][i] == mSw[i]) allDiff = 1'b0;
                end
                acc[i] = allDiff;
            end
        end
        mRise = acc & ~mSw;
        mFall = acc & mSw;
        mChg  = |acc;
        mSw   = mSw ^ acc;
    endtask

    // Drive one raw value, clock once, advance the model, compare everything.
    task automatic step(input logic [W-1:0] v);
        swRaw = v;
        @(posedge clk);
        if (rst) modelReset();
        else     modelEdge(v);
        #1;
        chk("sw",        sw,        mSw);
        chk("swRise",    swRise,    mRise);
        chk("swFall",    swFall,    mFall);
        chk("swChanged", swChanged, mChg);
    endtask

    initial begin
        int riseCnt;
        int pulseCnt;
        logic [W-1:0] rv;

        modelReset();

        // 1. Reset held with all switches high, then qualification after release.
        rst   = 1'b1;
        swRaw = 16'hFFFF;
        #1;
        chk("reset_sw",   sw,        16'h0000);
        chk("reset_rise", swRise,    16'h0000);
        chk("reset_chg",  swChanged, 1'b0);
        for (int k = 0; k < 3; k++) step(16'hFFFF);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(16'hFFFF);
            if (e == 5) chk("t1_sw_before", sw, 16'h0000);
            if (e == 6) begin
                chk("t1_sw_edge6",   sw,        16'hFFFF);
                chk("t1_rise_edge6", swRise,    16'hFFFF);
                chk("t1_chg_edge6",  swChanged, 1'b1);
            end
            if (e == 7) begin
                chk("t1_rise_after", swRise,    16'h0000);
                chk("t1_chg_after",  swChanged, 1'b0);
            end
        end

        // Return everything to 0.
        for (int k = 0; k < 8; k++) step(16'h0000);
        chk("t2_pre_sw", sw, 16'h0000);

        // 2. Single bit rising step.
        for (int e = 1; e <= 7; e++) begin
            step(16'h0008);
            if (e == 5) chk("t2_sw_before", sw, 16'h0000);
            if (e == 6) begin
                chk("t2_sw_edge6",   sw,     16'h0008);
                chk("t2_rise_edge6", swRise, 16'h0008);
                chk("t2_fall_edge6", swFall, 16'h0000);
            end
        end

        // 3. Bounce: 1,1,1,0 then 1 held; no early accept, one pulse only.
        for (int k = 0; k < 8; k++) step(16'h0000);
        riseCnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(16'h0008);
            if (swRise[3]) riseCnt++;
        end
        step(16'h0000);
        if (swRise[3]) riseCnt++;
        for (int e = 1; e <= 9; e++) begin
            step(16'h0008);
            if (swRise[3]) riseCnt++;
            if (e == 5) chk("t3_sw_before", sw, 16'h0000);
            if (e == 6) chk("t3_sw_edge6",  sw, 16'h0008);
        end
        chk("t3_rise_count", riseCnt, 1);

        // 4. Glitch on bit 7 shorter than the filter window.
        pulseCnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(16'h0088);
            if (swChanged) pulseCnt++;
        end
        for (int k = 0; k < 8; k++) begin
            step(16'h0008);
            if (swChanged) pulseCnt++;
        end
        chk("t4_sw_unchanged", sw, 16'h0008);
        chk("t4_no_pulses",    pulseCnt, 0);
        // A cleared count means a fresh step still needs the full latency.
        for (int e = 1; e <= 6; e++) begin
            step(16'h0088);
            if (e == 5) chk("t4_requal_before", sw, 16'h0008);
            if (e == 6) chk("t4_requal_edge6",  sw, 16'h0088);
        end

        // 5. Simultaneous rise and fall on different bits.
        for (int k = 0; k < 8; k++) step(16'h00F0);
        chk("t5_pre_sw", sw, 16'h00F0);
        for (int e = 1; e <= 7; e++) begin
            step(16'h0F00);
            if (e == 5) chk("t5_sw_before", sw, 16'h00F0);
            if (e == 6) begin
                chk("t5_sw_edge6",   sw,        16'h0F00);
                chk("t5_rise_edge6", swRise,    16'h0F00);
                chk("t5_fall_edge6", swFall,    16'h00F0);
                chk("t5_chg_edge6",  swChanged, 1'b1);
            end
            if (e == 7) chk("t5_chg_after", swChanged, 1'b0);
        end

        // 6. Asynchronous reset part-way through a count.
        for (int k = 0; k < 3; k++) step(16'h0F01);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_sw",   sw,        16'h0000);
        chk("t6_async_rise", swRise,    16'h0000);
        chk("t6_async_fall", swFall,    16'h0000);
        chk("t6_async_chg",  swChanged, 1'b0);
        modelReset();
        step(16'h0F01);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(16'h0F01);
            if (e == 5) chk("t6_sw_before", sw, 16'h0000);
            if (e == 6) begin
                chk("t6_sw_edge6",   sw,     16'h0F01);
                chk("t6_rise_edge6", swRise, 16'h0F01);
            end
        end

        // Random switch activity: sparse bit flips, often shorter than the window.
        rv = 16'h0F01;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                rv = rv ^ W'($urandom & $urandom & $urandom);
            end
            step(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
